// File: rtl/vga_timing_decoder.sv
// Sink-side VGA timing decoder: re-times the sync stream through a 2-stage pipeline,
// rebuilds hcount/vcount from blanking edges and verifies line/frame geometry for lock.
module vga_timing_decoder #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 628,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
);

    // state   | meaning
    // SEARCH  | waiting for the first vsync rise; errors are not reported
    // MEASURE | counting consecutive clean frames towards lock
    // LOCKED  | geometry verified; any error drops back to MEASURE
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [11:0] LINE_LEN  = 12'(H_TOTAL);
    localparam logic [11:0] LINE_TMO  = 12'(2 * H_TOTAL);
    localparam logic [10:0] FRAME_LEN = 11'(V_TOTAL);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX   = '1;

    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [11:0] line_cnt;
    logic        line_seen;
    logic        timed_out;
    logic [10:0] frame_cnt;
    logic        frame_end;
    state_t      state;
    logic [3:0]  good_frames;
    logic        frame_bad;

    logic hs_rise;
    logic vs_rise;
    logic hb_fall;
    logic vb_fall;
    logic report;
    logic line_bad;
    logic line_tmo;
    logic frame_miscount;

    // s1/s2 are packed {hsync, vsync, hblnk, vblnk}; s2 doubles as the output stage.
    assign {hsync, vsync, hblnk, vblnk} = s2;

    assign hs_rise = s1[3] & ~s2[3];
    assign vs_rise = s1[2] & ~s2[2];
    assign hb_fall = ~s1[1] & s2[1];
    assign vb_fall = ~s1[0] & s2[0];
    assign report  = (state != SEARCH);

    // A line that already timed out has been reported; its closing edge is not judged again.
    assign line_bad       = hs_rise & line_seen & ~timed_out & ((line_cnt + 12'd1) != LINE_LEN);
    assign line_tmo       = ~hs_rise & ~timed_out & (line_cnt == (LINE_TMO - 12'd1));
    assign frame_miscount = vs_rise & (frame_cnt != FRAME_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1        <= '0;
            s2        <= '0;
            hcount    <= '0;
            vcount    <= '0;
            line_cnt  <= '0;
            line_seen <= 1'b0;
            timed_out <= 1'b0;
            frame_cnt <= '0;
            frame_end <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            s1 <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
            s2 <= s1;

            if (hb_fall) begin
                hcount <= '0;
                if (vb_fall) begin
                    vcount <= '0;
                end else if (vcount != CNT_MAX) begin
                    vcount <= vcount + 11'd1;
                end
            end else if (hcount != CNT_MAX) begin
                hcount <= hcount + 11'd1;
            end

            if (hs_rise) begin
                line_cnt  <= '0;
                line_seen <= 1'b1;
                timed_out <= 1'b0;
            end else if (line_tmo) begin
                line_cnt  <= LINE_TMO;
                timed_out <= 1'b1;
            end else if (!timed_out) begin
                line_cnt <= line_cnt + 12'd1;
            end

            // An hsync rise coinciding with the vsync rise belongs to the new frame.
            if (vs_rise) begin
                frame_cnt <= hs_rise ? 11'd1 : 11'd0;
            end else if (hs_rise && frame_cnt != CNT_MAX) begin
                frame_cnt <= frame_cnt + 11'd1;
            end

            frame_end <= vs_rise;
            line_err  <= report & (line_bad | line_tmo);
            frame_err <= report & frame_miscount;
        end
    end

    // Frame judgement runs one cycle behind vs_rise so the closing frame_err is included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            good_frames <= '0;
            frame_bad   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (frame_end) begin
                        state       <= MEASURE;
                        good_frames <= '0;
                        frame_bad   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (frame_end) begin
                        frame_bad <= 1'b0;
                        if (frame_bad || line_err || frame_err) begin
                            good_frames <= '0;
                        end else if ((good_frames + 4'd1) == LOCK_N) begin
                            good_frames <= LOCK_N;
                            state       <= LOCKED;
                            locked      <= 1'b1;
                        end else begin
                            good_frames <= good_frames + 4'd1;
                        end
                    end else if (line_err || frame_err) begin
                        good_frames <= '0;
                        frame_bad   <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state       <= MEASURE;
                        locked      <= 1'b0;
                        good_frames <= '0;
                        frame_bad   <= ~frame_end;
                    end
                end
                default: begin
                    state       <= SEARCH;
                    good_frames <= '0;
                    frame_bad   <= 1'b0;
                    locked      <= 1'b0;
                end
            endcase
        end
    end

endmodule
